// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and the engine state type.
// Shared by the block engine and its message schedule.
// Pure declarations; no logic of its own.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: 16-word shift window, head word is W[t].
// Zero latency from window head to wt_out; load/shift take effect next edge.
// No backpressure; the parent decides when to load or shift.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block_in,
  output logic [31:0]  wt_out
);

  // Index 0 holds W[t]; index 15 holds W[t+15].
  logic [15:0][31:0] window_q, window_d;
  logic [31:0]       w_next;

  // Next window: load a fresh block (W0 from the MSBs) or shift in W[t+16].
  always_comb begin
    w_next   = ssig1(window_q[14]) + window_q[9] + ssig0(window_q[1]) + window_q[0];
    window_d = window_q;
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        window_d[i] = block_in[511 - 32*i -: 32];
      end
    end else if (shift) begin
      window_d = {w_next, window_q[15:1]};
    end
  end

  // Window register with synchronous clear.
  always_ff @(posedge clock) begin
    if (!reset_n) window_q <= '0;
    else          window_q <= window_d;
  end

  assign wt_out = window_q[0];

endmodule

// File: rtl/sha256_block_engine.sv
// SHA-256 compression of one 512-bit block, one round per clock.
// start edge to valid pulse is 66 clocks; hash_out held until the next final add.
// ready low while compressing; starts seen while ready is low are dropped.
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter bit ZEROIZE      = 1'b1,
  parameter bit READY_IN_OUT = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         init,
  input  logic [511:0] message_block,
  output logic         ready,
  output logic         valid,
  output logic [255:0] hash_out
);

  // Index 0 is a / H0 so the packed vectors line up with {H0..H7}.
  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [0:7][31:0]  work_q, work_d;
  logic [0:7][31:0]  chain_q, chain_d;
  logic [0:7][31:0]  h_q, h_d;
  logic              valid_q, valid_d;

  logic [0:7][31:0]  base;
  logic [31:0]       t1, t2, wt;
  logic              sch_load, sch_shift;
  logic [511:0]      sch_block;

  sha256_msg_schedule u_sched (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (sch_load),
    .shift    (sch_shift),
    .block_in (sch_block),
    .wt_out   (wt)
  );

  // Without READY_IN_OUT the valid cycle is spent not accepting work.
  assign ready    = (state_q == ST_IDLE) && (READY_IN_OUT || !valid_q);
  assign valid    = valid_q;
  assign hash_out = h_q;

  // Next-state, round datapath and final add.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    chain_d   = chain_q;
    h_d       = h_q;
    valid_d   = 1'b0;
    sch_load  = 1'b0;
    sch_shift = 1'b0;
    sch_block = message_block;
    base      = h_q;
    t1        = '0;
    t2        = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && ready) begin
          if (init) begin
            for (int i = 0; i < 8; i++) base[i] = IV[i];
          end
          work_d   = base;
          chain_d  = base;
          cnt_d    = '0;
          sch_load = 1'b1;
          state_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        t1 = work_q[7] + bsig1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6]) + K[cnt_q] + wt;
        t2 = bsig0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
        work_d = {t1 + t2, work_q[0], work_q[1], work_q[2],
                  work_q[3] + t1, work_q[4], work_q[5], work_q[6]};
        sch_shift = 1'b1;
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = chain_q[i] + work_q[i];
        valid_d = 1'b1;
        state_d = ST_IDLE;
        if (ZEROIZE) begin
          work_d    = '0;
          sch_load  = 1'b1;
          sch_block = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any block in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      chain_q <= '0;
      h_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      chain_q <= chain_d;
      h_q     <= h_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed bench for sha256_block_engine with a whole-block SHA-256 reference model.
// Model predicts ready/valid/hash_out per cycle; literal digests pin the model.
// Covers chaining, back-to-back starts, busy starts, mid-operation reset and zeroize.
module tb_sha256_block_engine;

  logic         clock = 1'b0;
  logic         reset_n, start, init;
  logic [511:0] message_block;
  logic         ready, valid;
  logic [255:0] hash_out;

  always #5 clock = ~clock;

  sha256_block_engine dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .init          (init),
    .message_block (message_block),
    .ready         (ready),
    .valid         (valid),
    .hash_out      (hash_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [31:0] MK [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV_M =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full-array SHA-256 compression of one block onto chaining value hin.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + MK[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // Transaction-level model: a block accepted at edge n completes at edge n+65.
  logic         m_ready = 1'b1, m_valid = 1'b0;
  logic [255:0] m_h = '0, m_pend = '0;
  int           m_cyc = 0, m_done = -1;
  bit           m_live = 1'b0;

  always @(posedge clock) begin
    m_cyc++;
    if (!reset_n) begin
      m_ready = 1'b1; m_valid = 1'b0; m_h = '0; m_done = -1; m_live = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (m_ready && start) begin
        m_pend  = compress(init ? IV_M : m_h, message_block);
        m_ready = 1'b0;
        m_done  = m_cyc + 65;
      end else if (m_cyc == m_done) begin
        m_h = m_pend; m_valid = 1'b1; m_ready = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_live) begin
      chk("cyc_valid", 512'(valid), 512'(m_valid));
      chk("cyc_ready", 512'(ready), 512'(m_ready));
      chk("cyc_hash", 512'(hash_out), 512'(m_h));
      if (valid === 1'b1) n_valid++;
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [511:0] ABC   = {24'h616263, 8'h80, 416'h0, 64'd24};
  localparam logic [511:0] EMPTY = {8'h80, 504'h0};
  localparam logic [447:0] MSG2  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  localparam logic [511:0] B1    = {MSG2, 8'h80, 56'h0};
  localparam logic [511:0] B2    = {448'h0, 64'd448};
  localparam logic [511:0] JUNK  = {16{32'hdeadbeef}};
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // Called at a negedge: issue one start, then wait (bounded) for valid.
  // lat counts negedges after the start edge up to the one that sees valid.
  task automatic run_block(input logic [511:0] blk, input logic ini, input bit inject, output int lat);
    start = 1'b1; init = ini; message_block = blk;
    @(posedge clock);
    @(negedge clock);
    lat = 1;
    while (valid !== 1'b1 && lat < 200) begin
      start = inject && (lat == 11 || lat == 41);
      init  = 1'b1;
      message_block = start ? JUNK : blk;
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
  endtask

  int lat, v0;

  initial begin
    reset_n = 1'b0; start = 1'b0; init = 1'b0; message_block = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_ready", 512'(ready), 512'(1));
    chk("reset_valid", 512'(valid), 512'(0));
    chk("reset_hash", 512'(hash_out), 512'(0));
    reset_n = 1'b1;

    // Model pinned to known digests.
    chk("model_abc", 512'(compress(IV_M, ABC)), 512'(D_ABC));
    chk("model_empty", 512'(compress(IV_M, EMPTY)), 512'(D_EMPTY));
    chk("model_two", 512'(compress(compress(IV_M, B1), B2)), 512'(D_TWO));

    // "abc" plus zeroize in the cycle after valid.
    @(negedge clock);
    run_block(ABC, 1'b1, 1'b0, lat);
    chk("abc_latency", 512'(lat), 512'(66));
    chk("abc_digest", 512'(hash_out), 512'(D_ABC));
    @(negedge clock);
    chk("zero_work", 512'(dut.work_q), 512'(0));
    chk("zero_sched", 512'(dut.u_sched.window_q), 512'(0));
    chk("hold_after_zero", 512'(hash_out), 512'(D_ABC));

    // Empty message.
    run_block(EMPTY, 1'b1, 1'b0, lat);
    chk("empty_digest", 512'(hash_out), 512'(D_EMPTY));

    // Two chained blocks, second start in the first block's valid cycle.
    @(negedge clock);
    run_block(B1, 1'b1, 1'b0, lat);
    run_block(B2, 1'b0, 1'b0, lat);
    chk("two_latency", 512'(lat), 512'(66));
    chk("two_digest", 512'(hash_out), 512'(D_TWO));

    // Starts during rounds 10 and 40 must be dropped.
    @(negedge clock);
    v0 = n_valid;
    run_block(ABC, 1'b1, 1'b1, lat);
    chk("busy_latency", 512'(lat), 512'(66));
    chk("busy_digest", 512'(hash_out), 512'(D_ABC));
    repeat (80) @(negedge clock);
    chk("busy_one_valid", 512'(n_valid - v0), 512'(1));

    // Reset at round 30 abandons the block.
    v0 = n_valid;
    start = 1'b1; init = 1'b1; message_block = ABC;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (30) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (80) @(negedge clock);
    chk("abort_no_valid", 512'(n_valid - v0), 512'(0));
    chk("abort_hash_cleared", 512'(hash_out), 512'(0));
    run_block(ABC, 1'b1, 1'b0, lat);
    chk("after_abort_latency", 512'(lat), 512'(66));
    chk("after_abort_digest", 512'(hash_out), 512'(D_ABC));
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
